// File: rtl/oam_dma_arbiter_if.sv
// Shared byte-wide memory bus bundle used on both sides of the sprite-DMA arbiter.
// The master drives address, write data and write enable; the slave returns read data.
interface oam_dma_arbiter_if;
  logic [15:0] address;
  logic [7:0]  o_data;
  logic        we;
  logic [7:0]  i_data;

  modport master (
    output address,
    output o_data,
    output we,
    input  i_data
  );

  modport slave (
    input  address,
    input  o_data,
    input  we,
    output i_data
  );
endinterface

// File: rtl/oam_dma_arbiter.sv
// Sprite-DMA arbiter: shares the memory bus between the 6502 core and an engine
// that copies one 256-byte page to the PPU OAM data port after a trigger write.
// While the engine runs, the core is frozen through cpu_locked. Every register
// update is gated by pll_locked, so a low pll_locked freezes the whole transfer.
module oam_dma_arbiter #(
  parameter logic [15:0] TRIG_ADDR = 16'h4014,
  parameter logic [15:0] DST_ADDR  = 16'h2004
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  pll_locked,
  oam_dma_arbiter_if.slave      cpu,
  oam_dma_arbiter_if.master     mem,
  output logic                  cpu_locked,
  output logic                  dma_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t     state_r;
  state_t     state_s;
  logic [7:0] page_r;
  logic [7:0] page_s;
  logic [7:0] idx_r;
  logic [7:0] idx_s;
  logic [7:0] buf_r;
  logic [7:0] buf_s;
  logic       trigger_s;

  // A core write of the page number to the trigger address starts a transfer.
  assign trigger_s = cpu.we && (cpu.address == TRIG_ADDR);

  // Next-state and datapath register values; everything holds while pll_locked is low.
  always_comb begin
    state_s = state_r;
    page_s  = page_r;
    idx_s   = idx_r;
    buf_s   = buf_r;
    if (pll_locked) begin
      case (state_r)
        IDLE: begin
          if (trigger_s) begin
            state_s = READ;
            page_s  = cpu.o_data;
            idx_s   = 8'h00;
          end else begin
            state_s = IDLE;
          end
        end
        READ: begin
          buf_s   = mem.i_data;
          state_s = WRITE;
        end
        WRITE: begin
          // idx increments within the page only; the page byte never sees a carry.
          idx_s = idx_r + 8'd1;
          if (idx_r == 8'hFF) begin
            state_s = IDLE;
          end else begin
            state_s = READ;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_r <= IDLE;
      page_r  <= 8'h00;
      idx_r   <= 8'h00;
      buf_r   <= 8'h00;
    end else begin
      state_r <= state_s;
      page_r  <= page_s;
      idx_r   <= idx_s;
      buf_r   <= buf_s;
    end
  end

  // Bus mux: the core owns the bus in IDLE, the engine in READ and WRITE.
  always_comb begin
    mem.address = cpu.address;
    mem.o_data  = cpu.o_data;
    mem.we      = cpu.we;
    case (state_r)
      IDLE: begin
        mem.address = cpu.address;
        mem.o_data  = cpu.o_data;
        mem.we      = cpu.we;
      end
      READ: begin
        mem.address = {page_r, idx_r};
        mem.o_data  = 8'h00;
        mem.we      = 1'b0;
      end
      WRITE: begin
        mem.address = DST_ADDR;
        mem.o_data  = buf_r;
        mem.we      = 1'b1;
      end
      default: begin
        mem.address = cpu.address;
        mem.o_data  = cpu.o_data;
        mem.we      = cpu.we;
      end
    endcase
  end

  // Read data always reaches the core directly; during DMA the core is frozen and ignores it.
  assign cpu.i_data = mem.i_data;

  // Core run enable and busy flag are decoded straight from the state register.
  assign cpu_locked = pll_locked & (state_r == IDLE);
  assign dma_busy   = (state_r != IDLE);

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Self-checking bench for oam_dma_arbiter: table-driven pass-through vectors,
// then DMA sequences checked by a scoreboard of expected source reads and OAM writes.
module tb_oam_dma_arbiter;
  localparam logic [15:0] TRIG = 16'h4014;
  localparam logic [15:0] DST  = 16'h2004;
  localparam int          BOUND = 2000;

  logic clock = 1'b0;
  logic resetn;
  logic pll_locked;
  logic cpu_locked;
  logic dma_busy;

  int checks = 0;
  int errors = 0;

  logic [15:0] src_q[$];
  logic [7:0]  dat_q[$];
  time         t_start;

  always #5 clock = ~clock;

  oam_dma_arbiter_if cpu_bus ();
  oam_dma_arbiter_if mem_bus ();

  oam_dma_arbiter #(.TRIG_ADDR(TRIG), .DST_ADDR(DST)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .pll_locked (pll_locked),
    .cpu        (cpu_bus),
    .mem        (mem_bus),
    .cpu_locked (cpu_locked),
    .dma_busy   (dma_busy)
  );

  // Memory contents: page 03 holds i^5A; other pages differ so a page carry is visible.
  function automatic logic [7:0] mem_model(input logic [15:0] a);
    return a[7:0] ^ 8'h5A ^ (a[15:8] - 8'h03);
  endfunction

  assign mem_bus.i_data = mem_model(mem_bus.address);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=missing required=present", name);
  endtask

  // Scoreboard monitor: each DMA cycle that will commit is compared to the expected queues.
  always @(negedge clock) begin
    logic [15:0] ea;
    logic [7:0]  ed;
    if (resetn && pll_locked && dma_busy) begin
      if (mem_bus.we) begin
        check("dst_addr", mem_bus.address, DST);
        if (dat_q.size() == 0) begin
          fail_now("unexpected_oam_write");
        end else begin
          ed = dat_q.pop_front();
          check("oam_data", mem_bus.o_data, ed);
        end
      end else begin
        if (src_q.size() == 0) begin
          fail_now("unexpected_src_read");
        end else begin
          ea = src_q.pop_front();
          check("src_addr", mem_bus.address, ea);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive a trigger now; the following posedge is E0.
  task automatic do_trigger(input logic [7:0] page);
    cpu_bus.address = TRIG;
    cpu_bus.o_data  = page;
    cpu_bus.we      = 1'b1;
    for (int i = 0; i < 256; i++) begin
      src_q.push_back({page, i[7:0]});
      dat_q.push_back(mem_model({page, i[7:0]}));
    end
    #1;
    check("trig_fwd_we", mem_bus.we, 1'b1);
    check("trig_fwd_addr", mem_bus.address, TRIG);
    check("trig_fwd_data", mem_bus.o_data, page);
    @(posedge clock);
    #1;
    cpu_bus.address = 16'h0000;
    cpu_bus.o_data  = 8'h00;
    cpu_bus.we      = 1'b0;
    @(negedge clock);
    t_start = $time;
    check("first_busy", dma_busy, 1'b1);
    check("first_locked", cpu_locked, 1'b0);
  endtask

  // Wait for the engine to present a READ of the given source address.
  task automatic wait_addr(input logic [15:0] a);
    bit found = 1'b0;
    for (int i = 0; i < BOUND; i++) begin
      @(negedge clock);
      if (dma_busy && !mem_bus.we && mem_bus.address == a) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) fail_now("wait_addr_timeout");
  endtask

  // Wait for release; returns at the negedge of the first IDLE cycle.
  task automatic wait_idle(input int exp_cycles);
    bit  done = 1'b0;
    time cyc;
    for (int i = 0; i < BOUND; i++) begin
      @(negedge clock);
      if (!dma_busy) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      fail_now("wait_idle_timeout");
    end else begin
      cyc = ($time - t_start) / 10;
      check("busy_cycles", cyc[31:0], exp_cycles);
      check("release_locked", cpu_locked, 1'b1);
      check("sb_drained", dat_q.size() + src_q.size(), 0);
    end
  endtask

  typedef struct {
    string       name;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        we;
    logic        pll;
    logic [15:0] exp_addr;
    logic [7:0]  exp_data;
    logic        exp_we;
    logic        exp_busy;
    logic        exp_locked;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [7:0] held;

    vecs[0] = '{"wr_2003",    16'h2003, 8'h77, 1'b1, 1'b1, 16'h2003, 8'h77, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{"rd_8000",    16'h8000, 8'h00, 1'b0, 1'b1, 16'h8000, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{"wr_2004",    16'h2004, 8'hAA, 1'b1, 1'b1, 16'h2004, 8'hAA, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{"rd_4014",    16'h4014, 8'h03, 1'b0, 1'b1, 16'h4014, 8'h03, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{"trig_nopll", 16'h4014, 8'h09, 1'b1, 1'b0, 16'h4014, 8'h09, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{"after_nopll",16'h1234, 8'h5A, 1'b0, 1'b1, 16'h1234, 8'h5A, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{"wr_4015",    16'h4015, 8'h01, 1'b1, 1'b1, 16'h4015, 8'h01, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{"after_4015", 16'h0000, 8'h00, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b1};

    resetn          = 1'b0;
    pll_locked      = 1'b1;
    cpu_bus.address = 16'h0000;
    cpu_bus.o_data  = 8'h00;
    cpu_bus.we      = 1'b0;

    // Reset: three cycles, bus must track the core.
    for (int i = 0; i < 3; i++) begin
      cpu_bus.address = 16'h1100 + 16'(i * 16'h0101);
      @(negedge clock);
      check("rst_busy", dma_busy, 1'b0);
      check("rst_locked", cpu_locked, 1'b1);
      check("rst_addr", mem_bus.address, 16'h1100 + 16'(i * 16'h0101));
      tick();
    end
    resetn = 1'b1;

    // Pass-through vectors, all applied while the core owns the bus.
    for (int v = 0; v < 8; v++) begin
      cpu_bus.address = vecs[v].addr;
      cpu_bus.o_data  = vecs[v].wdata;
      cpu_bus.we      = vecs[v].we;
      pll_locked      = vecs[v].pll;
      @(negedge clock);
      check({vecs[v].name, "_addr"},   mem_bus.address, vecs[v].exp_addr);
      check({vecs[v].name, "_data"},   mem_bus.o_data,  vecs[v].exp_data);
      check({vecs[v].name, "_we"},     mem_bus.we,      vecs[v].exp_we);
      check({vecs[v].name, "_busy"},   dma_busy,        vecs[v].exp_busy);
      check({vecs[v].name, "_locked"}, cpu_locked,      vecs[v].exp_locked);
      check({vecs[v].name, "_rdata"},  cpu_bus.i_data,  mem_model(vecs[v].exp_addr));
      tick();
    end
    cpu_bus.address = 16'h0000;
    cpu_bus.we      = 1'b0;
    pll_locked      = 1'b1;
    tick();

    // Basic transfer of page 03.
    do_trigger(8'h03);
    wait_idle(512);

    // Freeze for 10 cycles in WRITE at idx 40.
    do_trigger(8'h03);
    wait_addr(16'h0340);
    tick();
    pll_locked = 1'b0;
    held = mem_model(16'h0340);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("frz_we", mem_bus.we, 1'b1);
      check("frz_addr", mem_bus.address, DST);
      check("frz_buf", mem_bus.o_data, held);
      check("frz_busy", dma_busy, 1'b1);
      tick();
    end
    pll_locked = 1'b1;
    wait_idle(522);

    // Reset during WRITE at idx 10, then a fresh transfer from page 05.
    do_trigger(8'h03);
    wait_addr(16'h0310);
    tick();
    resetn = 1'b0;
    cpu_bus.address = 16'h0ABC;
    tick();
    resetn = 1'b1;
    @(negedge clock);
    check("rstmid_busy", dma_busy, 1'b0);
    check("rstmid_locked", cpu_locked, 1'b1);
    check("rstmid_addr", mem_bus.address, 16'h0ABC);
    check("rstmid_we", mem_bus.we, 1'b0);
    src_q.delete();
    dat_q.delete();
    do_trigger(8'h05);
    wait_idle(512);

    // Page FF without carry, then a retrigger on the first free cycle.
    do_trigger(8'hFF);
    wait_idle(512);
    do_trigger(8'h03);
    wait_idle(512);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/oam_dma_arbiter.md
# oam_dma_arbiter

Shares the single memory bus between the 6502 core and a sprite-DMA engine. A CPU write of page number P to the trigger address stalls the core via its `locked` input. The engine then copies 256 bytes from P:00..P:FF to the PPU OAM data port and returns the bus to the core. The block sits between the core's bus pins and the memory/peripheral decoder.

## Interface
Parameters:
- TRIG_ADDR, 16'h4014, CPU write address that starts a transfer
- DST_ADDR, 16'h2004, fixed destination address for every DMA write

Ports:
- clock  input  1  system clock, 25 MHz
- resetn  input  1  synchronous, active-low reset; clock clock
- pll_locked  input  1  global run enable; 0 freezes this block and the core
- cpu_address  input  16  core bus address
- cpu_o_data  input  8  core write data
- cpu_we  input  1  core write enable
- cpu_i_data  output  8  read data to core; equals mem_i_data at all times
- cpu_locked  output  1  drives the core's `locked` input
- mem_address  output  16  shared bus address
- mem_o_data  output  8  shared bus write data
- mem_we  output  1  shared bus write enable
- mem_i_data  input  8  shared bus read data, valid in the same cycle as mem_address (combinational read)
- dma_busy  output  1  high while the engine owns the bus

## Operation
- States: IDLE, READ, WRITE. Registers: state, page[7:0], idx[7:0], buf[7:0].
- Bus mux:
  - IDLE: mem_address/mem_o_data/mem_we = cpu_address/cpu_o_data/cpu_we.
  - READ: mem_address={page,idx}, mem_we=0.
  - WRITE: mem_address=DST_ADDR, mem_o_data=buf, mem_we=1.
- cpu_locked = pll_locked & (state==IDLE). dma_busy = (state!=IDLE). Both are combinational from registers.
- All register updates are gated by pll_locked. With pll_locked=0, nothing changes.
- IDLE -> READ on a clock edge with cpu_we=1 and cpu_address==TRIG_ADDR. On that edge, page<=cpu_o_data and idx<=0.
  - The trigger write itself is still forwarded to memory in that cycle, since the mux is still on the CPU.
- READ -> WRITE: buf<=mem_i_data.
- WRITE -> READ: idx<=idx+1, if idx!=8'hFF.
- WRITE -> IDLE: if idx==8'hFF. idx wraps to 0 and is don't-care afterwards.
- Source address never carries into the page byte. Exactly 256 bytes are moved per trigger.
- Writes by the core to any address other than TRIG_ADDR pass through with no side effects.
- A trigger cannot occur during a transfer because the core is frozen. A trigger on the first IDLE cycle after a transfer starts a new transfer normally.

## Timing
- Reset values:
  - state=IDLE, page=0, idx=0, buf=0.
  - Hence dma_busy=0 and cpu_locked=pll_locked.
  - mem_* follow cpu_*.
- Reset asserted mid-transfer: the next edge forces IDLE and the bus returns to the CPU immediately. Any remaining bytes are abandoned.
- Edge E0 captures the trigger. The first DMA cycle (READ, idx=0) is the cycle after E0. In that same cycle cpu_locked drops, so the core is held at its next-opcode fetch state.
- Each byte takes 2 cycles (READ, WRITE). A transfer is 512 cycles of dma_busy=1.
- cpu_locked returns to 1 in the cycle after the last WRITE (idx=FF). The core resumes on that cycle.
- The stall is exactly 512 clocks plus any pll_locked=0 cycles.
- pll_locked low mid-transfer: state, idx and buf hold. The mux keeps its current output, and mem_we stays at its state value. Because a held WRITE asserts mem_we for several cycles, the destination device counts writes only on pll_locked edges.
- Interrupts are not handled here. A pending intr is taken by the core after release.

## Test plan
- Reset: hold resetn=0 for 3 cycles with pll_locked=1 -> dma_busy=0, cpu_locked=1, mem_address tracks cpu_address.
- Basic transfer: preload 0x0300+i = i^8'h5A; core writes 8'h03 to 4014 -> 256 writes at 2004 with data 5A,5B,...,A5 in order. dma_busy is high for exactly 512 cycles, then cpu_locked=1.
- Pass-through: core writes 8'h77 to 2003 and reads 0x8000 -> mem_we/mem_address/mem_o_data mirror the core and cpu_i_data equals memory. No DMA starts.
- Freeze: drop pll_locked for 10 cycles at idx=0x40 in WRITE -> idx/buf unchanged during the freeze. The total transfer still delivers 256 correct bytes, and dma_busy lasts 522 cycles.
- Reset mid-transfer: assert resetn=0 at idx=0x10 -> next cycle is IDLE with cpu_locked=1. A new trigger with page 8'h05 restarts from 0x0500.
- Page boundary and back-to-back: page 8'hFF copies FF00..FFFF with no carry into 0000. A retrigger on the first free cycle starts a second 512-cycle transfer.
